// File: rtl/priority_req_sequencer_if.sv
// Interface between the sequencer, the 16-input encoder and the downstream
// interrupt consumer. The slave modport is the sequencer; the master modport is
// the environment that drives requests, returns the encoder code and accepts offers.
//   req_in    : raw asynchronous request lines
//   mask      : hides pending bits from the encoder; the bits are kept
//   pend_vec  : pending & ~mask, fed to the encoder
//   enc_code  : encoder result; upper nibble nonzero means no request
//   irq_*     : valid/ready offer of the winning index
//   ovr_flags : sticky overrun flags; ovr_clr clears them all
//   busy      : high while an offer is outstanding
interface priority_req_sequencer_if;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned IDX_W = 4;
  localparam int unsigned CODE_W = 8;

  logic [WIDTH-1:0]  req_in;
  logic [WIDTH-1:0]  mask;
  logic [WIDTH-1:0]  pend_vec;
  logic [CODE_W-1:0] enc_code;
  logic              irq_valid;
  logic [IDX_W-1:0]  irq_index;
  logic              irq_ready;
  logic [WIDTH-1:0]  ovr_flags;
  logic              ovr_clr;
  logic              busy;

  modport master (
    output req_in, mask, enc_code, irq_ready, ovr_clr,
    input  pend_vec, irq_valid, irq_index, ovr_flags, busy
  );

  modport slave (
    input  req_in, mask, enc_code, irq_ready, ovr_clr,
    output pend_vec, irq_valid, irq_index, ovr_flags, busy
  );
endinterface

// File: rtl/priority_req_sequencer.sv
// Front-end and retirement stage for a 16-input priority encoder.
// Synchronises raw requests, captures events into sticky pending bits, presents
// the masked pending vector to the encoder, offers the encoder's winner on a
// valid/ready handshake and retires the served bit on acceptance.
// Ports:
//   clk : clock
//   rst : asynchronous active-high reset
//   bus : priority_req_sequencer_if.slave (requests, mask, encoder loop,
//         offer handshake, overrun flags, busy)
module priority_req_sequencer #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned SYNC_STAGES = 2,
  parameter bit          EDGE_MODE   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  priority_req_sequencer_if.slave  bus
);
  localparam int unsigned IDX_W = 4;

  typedef enum logic {IDLE, OFFER} state_t;

  state_t                               state_q;
  logic [SYNC_STAGES-1:0][WIDTH-1:0]    sync_q;
  logic [WIDTH-1:0]                     sync_s;
  logic [WIDTH-1:0]                     hist_q;
  logic [WIDTH-1:0]                     event_c;
  logic [WIDTH-1:0]                     clr_c;
  logic [WIDTH-1:0]                     pending_q;
  logic [WIDTH-1:0]                     ovr_q;
  logic                                 accept_c;
  logic                                 valid_q;
  logic                                 busy_q;
  logic [IDX_W-1:0]                     index_q;

  assign sync_s = sync_q[SYNC_STAGES-1];

  // Request event: rising edge of the synchronised line, or its level.
  generate
    if (EDGE_MODE) begin : g_edge
      assign event_c = sync_s & ~hist_q;
    end else begin : g_level
      assign event_c = sync_s;
    end
  endgenerate

  // One-hot retire vector for the offered index on acceptance.
  assign accept_c = (state_q == OFFER) && bus.irq_ready;
  assign clr_c    = accept_c ? (WIDTH'(1) << index_q) : '0;

  // Synchroniser chain plus edge-history flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= bus.req_in;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
      hist_q <= sync_s;
    end
  end

  // Pending bits: a set in the same cycle as a retire wins. Overrun only when
  // the bit is already pending and is not being retired this cycle; an overrun
  // event wins over ovr_clr for its own bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      ovr_q     <= '0;
    end else begin
      pending_q <= (pending_q & ~clr_c) | event_c;
      ovr_q     <= (bus.ovr_clr ? '0 : ovr_q) | (event_c & pending_q & ~clr_c);
    end
  end

  // Offer FSM: lookup in IDLE, hold the offer in OFFER until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      index_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.enc_code[7:4] == 4'h0) begin
            index_q <= bus.enc_code[3:0];
            valid_q <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (bus.irq_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  // pend_vec is combinational so the encoder sees the current masked state.
  assign bus.pend_vec  = pending_q & ~bus.mask;
  assign bus.irq_valid = valid_q;
  assign bus.irq_index = index_q;
  assign bus.busy      = busy_q;
  assign bus.ovr_flags = ovr_q;
endmodule

// File: doc/priority_req_sequencer.md
Name: priority_req_sequencer

Overview:
- Front-end and retirement stage paired with the 16-input priority encoder.
- Synchronises 16 raw request lines, captures rising edges into sticky pending bits, and drives the masked pending vector into the encoder.
- Takes the encoder's 8-bit code back, offers the winning index downstream on a valid/ready handshake, and clears the served pending bit on acceptance.

Parameters:
- WIDTH, 16: number of request lines; fixed to match the encoder's 16 inputs.
- SYNC_STAGES, 2: synchroniser flops per request line; legal values 1 to 3.
- EDGE_MODE, 1: 1 means a rising edge sets pending; 0 means a high level sets pending on every cycle.

Ports:
- clk  input  1  clock.
- rst  input  1  reset, asynchronous, active-high.
- req_in  input  16  raw asynchronous request lines.
- mask  input  16  1 = hide that pending bit from the encoder; the pending bit is retained.
- pend_vec  output  16  pending AND NOT mask, driven to the encoder's 16-bit input.
- enc_code  input  8  encoder result; 0..15 = winning index; any nonzero upper nibble (0xF0) = none.
- irq_valid  output  1  offer valid.
- irq_index  output  4  offered index.
- irq_ready  input  1  downstream accept.
- ovr_flags  output  16  sticky overrun flag per line.
- ovr_clr  input  1  clears all ovr_flags.
- busy  output  1  high while in OFFER.

Behaviour:
- Interface: one clock (clk). Reset rst is asynchronous and active-high.
- Reset: clears sync chains, edge-history regs, pending, ovr_flags, and the FSM (to IDLE).
  - Outputs during and after reset: irq_valid=0, irq_index=0, busy=0, pend_vec=0.
  - Edge history resets to 0, so a line held high through reset release registers one edge.
- Synchroniser: req_in passes through SYNC_STAGES flops to give s, then one history flop h.
  - Edge = s & ~h in EDGE_MODE=1; level = s in EDGE_MODE=0.
  - Latency: the first clock sampling req_in high is edge k. The pending bit is high after edge k+SYNC_STAGES, i.e. visible on pend_vec in the following cycle.
- pend_vec is combinational from the pending reg and mask; no extra register.
- enc_code is treated as combinational from pend_vec and is sampled in the same cycle.
- FSM states: IDLE and OFFER.
  - IDLE: if enc_code[7:4]==0, latch irq_index=enc_code[3:0] and go to OFFER; otherwise stay in IDLE.
  - OFFER: irq_valid=1, busy=1; irq_index held stable.
  - OFFER, on irq_valid & irq_ready at an edge: clear pending[irq_index] at that edge, go to IDLE. irq_valid is low for at least one cycle between offers.
  - OFFER, no ready: hold indefinitely.
  - No preemption: a higher-priority arrival during OFFER waits for the next IDLE lookup.
  - Masking the offered bit during OFFER does not withdraw the offer.
- Set and clear of the same pending bit in the same cycle: set wins, the bit stays 1, and no overrun is flagged.
- Overrun: an edge/level event on a bit that is already pending and not being cleared that cycle sets ovr_flags[bit]. In EDGE_MODE=0 this fires every cycle the level persists.
- ovr_clr clears all ovr_flags at the edge; an overrun event in the same cycle wins for its bit.
- Serial throughput: at most one offer per 2 cycles.

Test Plan:
- Reset / sync latency: assert rst with req_in=0 -> all outputs 0. Release rst; raise req_in[3] (SYNC_STAGES=2) -> pend_vec=0x0008 after edge k+2. irq_valid rises the cycle after pend_vec rises, with irq_index=3.
- Priority: raise req_in[5] and req_in[12] together, irq_ready=0 -> irq_index=12 held with valid high. Pulse ready -> bit 12 clears; after one low cycle, valid returns with index 5.
- No preemption / mask: while index 5 is offered, raise req_in[14] -> index stays 5 until accepted, then 14 is offered. Set mask=0x4000 beforehand -> pend_vec hides bit 14 and no offer occurs; clear the mask -> index 14 is offered.
- Overrun and clear: pending[7]=1 and unserved, pulse req_in[7] again -> ovr_flags=0x0080. Pulse ovr_clr -> 0x0000.
- Set/clear collision: an edge on the offered bit 2 arriving in the acceptance cycle -> pending[2] stays 1, no overrun, and index 2 is re-offered.
- Async reset mid-OFFER: rst asserted while irq_valid=1 -> irq_valid drops immediately without waiting for clk. req_in[9] held high through release -> pending[9] is set after SYNC_STAGES edges and offered once.
